// File: rtl/saturn_bus_fetch.sv
// Saturn nibble-bus fetch controller: LOAD_PC command, 5 address nibbles, PC_READ, then streaming.
// Define SATURN_BUS_ADDR_SHADOW_EN to build the shadow-address mismatch checker.
module saturn_bus_fetch #(
   parameter logic [3:0] LOAD_PC_CMD = 4'h4,
   parameter logic [3:0] PC_READ_CMD = 4'h2
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_clk_en,
   input  logic [3:0]  i_phases,
   input  logic [19:0] i_current_pc,
   input  logic        i_reload_pc,
   input  logic [3:0]  i_bus_data,
   output logic [3:0]  o_bus_data,
   output logic        o_bus_strobe,
   output logic        o_bus_cmd,
   output logic        o_bus_busy,
   output logic [3:0]  o_nibble,
   output logic        o_pc_mismatch
);

   typedef enum logic [2:0] {
      S_LOAD_CMD  = 3'd0,
      S_LOAD_ADDR = 3'd1,
      S_READ_CMD  = 3'd2,
      S_SETTLE    = 3'd3,
      S_STREAM    = 3'd4
   } state_t;

   state_t      state_r;
   logic [19:0] addr_sr_r;
   logic [2:0]  count_r;
   logic        reload_q_r;
   logic        reload_pend_r;

   logic        step_s;
   logic        ph0_s;
   logic        ph1_s;
   logic        ph3_s;
   logic        reload_fall_s;
   logic        honor_s;

   assign step_s        = i_clk_en & (|i_phases);
   assign ph0_s         = i_clk_en & i_phases[0];
   assign ph1_s         = i_clk_en & i_phases[1];
   assign ph3_s         = i_clk_en & i_phases[3];
   assign reload_fall_s = step_s & reload_q_r & ~i_reload_pc;
   assign honor_s       = ph0_s & (state_r == S_STREAM) & reload_pend_r;
   assign o_bus_busy    = (state_r != S_STREAM);

   // Bus sequencer: bus outputs are one-cycle pulses that fall back to 0 unless re-driven.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_r      <= S_LOAD_CMD;
         addr_sr_r    <= 20'h00000;
         count_r      <= 3'd0;
         o_bus_data   <= 4'h0;
         o_bus_strobe <= 1'b0;
         o_bus_cmd    <= 1'b0;
      end else begin
         o_bus_data   <= 4'h0;
         o_bus_strobe <= 1'b0;
         o_bus_cmd    <= 1'b0;
         if (ph0_s) begin
            case (state_r)
               S_LOAD_CMD: begin
                  o_bus_data   <= LOAD_PC_CMD;
                  o_bus_cmd    <= 1'b1;
                  o_bus_strobe <= 1'b1;
                  addr_sr_r    <= i_current_pc;
                  count_r      <= 3'd0;
                  state_r      <= S_LOAD_ADDR;
               end
               S_LOAD_ADDR: begin
                  o_bus_data   <= addr_sr_r[3:0];
                  o_bus_strobe <= 1'b1;
                  addr_sr_r    <= {4'h0, addr_sr_r[19:4]};
                  count_r      <= count_r + 3'd1;
                  if (count_r == 3'd4) begin
                     state_r <= S_READ_CMD;
                  end
               end
               S_READ_CMD: begin
                  o_bus_data   <= PC_READ_CMD;
                  o_bus_cmd    <= 1'b1;
                  o_bus_strobe <= 1'b1;
                  state_r      <= S_SETTLE;
               end
               S_SETTLE: begin
                  state_r <= S_SETTLE;
               end
               S_STREAM: begin
                  // A pending jump takes this slot instead of a fetch.
                  if (reload_pend_r) begin
                     state_r <= S_LOAD_CMD;
                  end else begin
                     o_bus_strobe <= 1'b1;
                  end
               end
               default: begin
                  state_r <= S_LOAD_CMD;
               end
            endcase
         end else if (ph3_s && (state_r == S_SETTLE)) begin
            state_r <= S_STREAM;
         end
      end
   end

   // Instruction nibble capture on the phase-1 step of a streaming cycle.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_nibble <= 4'h0;
      end else if (ph1_s && (state_r == S_STREAM)) begin
         o_nibble <= i_bus_data;
      end
   end

   // Jump detection: remember a falling edge of i_reload_pc until it is honoured.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         reload_q_r    <= 1'b0;
         reload_pend_r <= 1'b0;
      end else if (step_s) begin
         reload_q_r    <= i_reload_pc;
         reload_pend_r <= (reload_pend_r & ~honor_s) | reload_fall_s;
      end
   end

`ifdef SATURN_BUS_ADDR_SHADOW_EN
   logic [19:0] shadow_r;
   logic        ph2_s;
   logic        fetch_s;

   assign ph2_s   = i_clk_en & i_phases[2];
   assign fetch_s = ph0_s & (state_r == S_STREAM) & ~reload_pend_r;

   // Shadow PC follows every fetch; any divergence from the PC/RSTK unit is sticky.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         shadow_r      <= 20'h00000;
         o_pc_mismatch <= 1'b0;
      end else begin
         if (ph0_s && (state_r == S_LOAD_CMD)) begin
            shadow_r <= i_current_pc;
         end else if (fetch_s) begin
            shadow_r <= shadow_r + 20'd1;
         end
         if (ph2_s && (state_r == S_STREAM) && (shadow_r != i_current_pc)) begin
            o_pc_mismatch <= 1'b1;
         end
      end
   end
`else
   assign o_pc_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_saturn_bus_fetch.sv
// Self-checking bench for saturn_bus_fetch: sequence-level reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_saturn_bus_fetch;

`ifdef SATURN_BUS_ADDR_SHADOW_EN
   localparam bit SHADOW = 1'b1;
`else
   localparam bit SHADOW = 1'b0;
`endif

   logic        i_clk = 1'b0;
   logic        i_reset_n = 1'b0;
   logic        i_clk_en = 1'b0;
   logic [3:0]  i_phases = 4'b0001;
   logic [19:0] i_current_pc = 20'h0;
   logic        i_reload_pc = 1'b0;
   logic [3:0]  i_bus_data = 4'h0;
   logic [3:0]  o_bus_data;
   logic        o_bus_strobe;
   logic        o_bus_cmd;
   logic        o_bus_busy;
   logic [3:0]  o_nibble;
   logic        o_pc_mismatch;

   int checks = 0;
   int failures = 0;

   saturn_bus_fetch dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_clk_en(i_clk_en), .i_phases(i_phases),
      .i_current_pc(i_current_pc), .i_reload_pc(i_reload_pc), .i_bus_data(i_bus_data),
      .o_bus_data(o_bus_data), .o_bus_strobe(o_bus_strobe), .o_bus_cmd(o_bus_cmd),
      .o_bus_busy(o_bus_busy), .o_nibble(o_nibble), .o_pc_mismatch(o_pc_mismatch)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: position in the addressing sequence counted in phase-0 slots
   // (0 = load cmd, 1..5 = address nibble n-1, 6 = read cmd, 7 = waiting for phase 3, 8 = streaming).
   int          m_idx = 0;
   logic [19:0] m_pc = 20'h0;
   logic [19:0] m_shadow = 20'h0;
   logic        m_rq = 1'b0;
   logic        m_pend = 1'b0;
   logic [3:0]  e_data = 4'h0;
   logic [3:0]  e_nib = 4'h0;
   logic        e_strobe = 1'b0;
   logic        e_cmd = 1'b0;
   logic        e_mis = 1'b0;

   task automatic model_reset();
      m_idx = 0; m_pc = 20'h0; m_shadow = 20'h0; m_rq = 1'b0; m_pend = 1'b0;
      e_data = 4'h0; e_nib = 4'h0; e_strobe = 1'b0; e_cmd = 1'b0; e_mis = 1'b0;
   endtask

   task automatic model_step();
      logic fall;
      logic honor;
      if (!i_reset_n) begin
         model_reset();
      end else begin
         e_strobe = 1'b0; e_data = 4'h0; e_cmd = 1'b0;
         if (i_clk_en) begin
            fall  = m_rq && !i_reload_pc;
            honor = 1'b0;
            if (i_phases[0]) begin
               if (m_idx == 0) begin
                  e_strobe = 1'b1; e_cmd = 1'b1; e_data = 4'h4;
                  m_pc = i_current_pc; m_shadow = i_current_pc; m_idx = 1;
               end else if (m_idx <= 5) begin
                  e_strobe = 1'b1;
                  e_data = 4'((m_pc >> (4 * (m_idx - 1))) & 20'hF);
                  m_idx++;
               end else if (m_idx == 6) begin
                  e_strobe = 1'b1; e_cmd = 1'b1; e_data = 4'h2; m_idx = 7;
               end else if (m_idx == 8) begin
                  if (m_pend) begin
                     honor = 1'b1; m_idx = 0;
                  end else begin
                     e_strobe = 1'b1; m_shadow = m_shadow + 20'd1;
                  end
               end
            end
            if (i_phases[1] && m_idx == 8) e_nib = i_bus_data;
            if (i_phases[2] && m_idx == 8 && m_shadow != i_current_pc) e_mis = SHADOW;
            if (i_phases[3] && m_idx == 7) m_idx = 8;
            m_pend = (m_pend && !honor) || fall;
            m_rq = i_reload_pc;
         end
      end
   endtask

   logic [4:0] sq[$];
   logic [4:0] lit_q[$];

   // Compare process: outputs after each rising edge are checked at the following falling edge.
   initial begin
      forever begin
         @(negedge i_clk);
         if (!i_reset_n) model_reset();
         chk("strobe", o_bus_strobe, e_strobe);
         chk("bus_data", o_bus_data, e_data);
         chk("bus_cmd", o_bus_cmd, e_cmd);
         chk("busy", o_bus_busy, (m_idx != 8));
         chk("nibble", o_nibble, e_nib);
         chk("pc_mismatch", o_pc_mismatch, e_mis);
         if (o_bus_strobe) sq.push_back({o_bus_cmd, o_bus_data});
         model_step();
      end
   end

   // Stimulus state
   int          ph = 0;
   bit          en_next = 1'b1;
   bit          track = 1'b1;
   logic        rl_v = 1'b0;
   logic [19:0] pc_v = 20'h0;
   logic [3:0]  bus_q[$];

   task automatic tick();
      bit changed;
      @(posedge i_clk);
      #1;
      changed = i_clk_en;
      if (i_clk_en) ph = (ph + 1) % 4;
      if (track && o_bus_strobe && !o_bus_cmd && !o_bus_busy) pc_v = pc_v + 20'd1;
      i_phases = 4'(4'b0001 << ph);
      i_current_pc = pc_v;
      i_reload_pc = rl_v;
      i_clk_en = en_next;
      if (changed) begin
         if (ph == 1 && bus_q.size() > 0) i_bus_data = bus_q.pop_front();
         else i_bus_data = 4'($urandom_range(0, 15));
      end
   endtask

   task automatic wait_and_compare(input string name);
      int t = 0;
      while (sq.size() < lit_q.size() && t < 800) begin tick(); t++; end
      chk({name, "_count"}, (sq.size() >= lit_q.size()), 1);
      foreach (lit_q[i]) begin
         if (i < sq.size()) chk($sformatf("%s_%0d", name, i), sq[i], lit_q[i]);
      end
   endtask

   task automatic wait_busy(input logic level, input string name);
      int t = 0;
      while (o_bus_busy !== level && t < 200) begin tick(); t++; end
      chk(name, o_bus_busy, level);
   endtask

   task automatic jump(input logic [19:0] pc);
      track = 1'b0; pc_v = pc; rl_v = 1'b1;
      tick(); tick();
      rl_v = 1'b0;
      wait_busy(1'b1, "jump_busy");
      sq.delete();
   endtask

   task automatic wait_strobe_count(input int n);
      int t = 0;
      while (sq.size() < n && t < 200) begin tick(); t++; end
      chk("strobe_progress", (sq.size() >= n), 1);
   endtask

   initial begin
      logic [3:0] nib_exp[3];
      int k;
      i_reset_n = 1'b0;
      en_next = 1'b1; pc_v = 20'h0; rl_v = 1'b0;
      repeat (3) tick();
      chk("rst_busy", o_bus_busy, 1);
      chk("rst_strobe", o_bus_strobe, 0);
      chk("rst_data", o_bus_data, 0);
      chk("rst_cmd", o_bus_cmd, 0);
      chk("rst_nibble", o_nibble, 0);
      chk("rst_mismatch", o_pc_mismatch, 0);
      sq.delete();
      i_reset_n = 1'b1;

      // First sequence after reset loads PC 00000.
      lit_q = {5'h14, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h12};
      wait_and_compare("boot_seq");
      wait_busy(1'b0, "boot_busy_low");

      // Streaming: bus returns 3, A, F.
      nib_exp = '{4'h3, 4'hA, 4'hF};
      bus_q = {4'h3, 4'hA, 4'hF};
      k = 0;
      for (int i = 0; i < 16 && k < 3; i++) begin
         tick();
         chk("stream_busy", o_bus_busy, 0);
         if (i_clk_en && ph == 2) begin
            chk($sformatf("stream_nib_%0d", k), o_nibble, nib_exp[k]);
            k++;
         end
      end
      chk("stream_nib_count", k, 3);
      track = 1'b1;

      // Jump to 12345.
      jump(20'h12345);
      lit_q = {5'h14, 5'h05, 5'h04, 5'h03, 5'h02, 5'h01, 5'h12};
      wait_and_compare("jump_seq");
      wait_busy(1'b0, "jump_busy_low");
      track = 1'b1;

      // Reload falling edge during address phase: sequence completes, then one full reload.
      jump(20'hA0000);
      wait_strobe_count(3);
      pc_v = 20'h6789A; rl_v = 1'b1;
      tick(); tick();
      rl_v = 1'b0;
      lit_q = {5'h14, 5'h00, 5'h00, 5'h00, 5'h00, 5'h0A, 5'h12,
               5'h14, 5'h0A, 5'h09, 5'h08, 5'h07, 5'h06, 5'h12};
      wait_and_compare("mid_addr_reload");
      wait_busy(1'b0, "mid_addr_busy_low");
      track = 1'b1;

      // Clock enable low for 10 cycles mid-address.
      jump(20'h54321);
      wait_strobe_count(3);
      en_next = 1'b0;
      repeat (10) tick();
      chk("clken_no_strobes", sq.size(), 3);
      en_next = 1'b1;
      lit_q = {5'h14, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h12};
      wait_and_compare("clken_seq");
      wait_busy(1'b0, "clken_busy_low");
      track = 1'b1;

      // Randomized traffic checked by the model.
      begin
         int rl_cnt = 0;
         for (int i = 0; i < 3000; i++) begin
            en_next = ($urandom_range(0, 7) != 0);
            if (rl_cnt > 0) begin
               rl_cnt--;
               if (rl_cnt == 0) rl_v = 1'b0;
            end else if ($urandom_range(0, 60) == 0) begin
               rl_v = 1'b1;
               pc_v = 20'($urandom_range(0, 20'hFFFFF));
               rl_cnt = $urandom_range(1, 6);
            end
            tick();
         end
         rl_v = 1'b0; en_next = 1'b1;
         repeat (4) tick();
      end

      // Shadow check: stream across the FFFFF -> 00000 wrap, then skew the PC.
      i_reset_n = 1'b0;
      track = 1'b1; pc_v = 20'hFFFFE; rl_v = 1'b0; en_next = 1'b1;
      repeat (3) tick();
      i_reset_n = 1'b1;
      sq.delete();
      lit_q = {5'h14, 5'h0E, 5'h0F, 5'h0F, 5'h0F, 5'h0F, 5'h12};
      wait_and_compare("wrap_seq");
      wait_busy(1'b0, "wrap_busy_low");
      repeat (16) tick();
      chk("wrap_no_mismatch", o_pc_mismatch, 0);
      pc_v = pc_v + 20'd1;
      repeat (8) tick();
      chk("skew_mismatch", o_pc_mismatch, SHADOW);
      pc_v = pc_v - 20'd1;
      repeat (8) tick();
      chk("mismatch_sticky", o_pc_mismatch, SHADOW);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
